// File: rtl/phase_measure.sv
// Measures the period of a divided reference and the delay from its rising edge
// to the first rising edge of a second divided signal, with a cycle-count timeout.
module phase_measure #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ina_div,
  input  logic             inb_div,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] delay_cnt,
  output logic             no_b,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_A, MEAS, DONE} state_t;

  state_t           r_state, w_state_next;
  logic             r_ina_q, r_inb_q, r_hist_vld;
  logic [CNT_W-1:0] r_timer, w_timer_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_delay, w_delay_next;
  logic             r_got_b, w_got_b_next;
  logic [CNT_W-1:0] r_period, w_period_next;
  logic [CNT_W-1:0] r_delay_out, w_delay_out_next;
  logic             r_no_b, w_no_b_next;
  logic             r_timeout, w_timeout_next;
  logic             w_rise_a, w_rise_b, w_tmo;

  // Edges are suppressed until the history register holds a real sample.
  assign w_rise_a = r_hist_vld & ina_div & ~r_ina_q;
  assign w_rise_b = r_hist_vld & inb_div & ~r_inb_q;
  assign w_tmo    = (r_timer == TMO_LAST);

  always_comb begin
    w_state_next     = r_state;
    w_timer_next     = r_timer;
    w_cnt_next       = r_cnt;
    w_delay_next     = r_delay;
    w_got_b_next     = r_got_b;
    w_period_next    = r_period;
    w_delay_out_next = r_delay_out;
    w_no_b_next      = r_no_b;
    w_timeout_next   = r_timeout;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = WAIT_A;
          w_timer_next = '0;
          w_cnt_next   = '0;
          w_delay_next = '0;
          w_got_b_next = 1'b0;
        end
      end
      WAIT_A: begin
        w_timer_next = r_timer + 1'b1;
        if (w_tmo) begin
          w_state_next     = DONE;
          w_period_next    = '0;
          w_delay_out_next = '0;
          w_no_b_next      = 1'b1;
          w_timeout_next   = 1'b1;
        end else if (w_rise_a) begin
          w_state_next = MEAS;
          w_cnt_next   = CNT_W'(1);
          if (w_rise_b) begin
            w_delay_next = '0;
            w_got_b_next = 1'b1;
          end
        end
      end
      MEAS: begin
        w_timer_next = r_timer + 1'b1;
        // The closing edge takes priority over a timeout in the same cycle.
        if (w_rise_a) begin
          w_state_next     = DONE;
          w_period_next    = r_cnt;
          w_delay_out_next = r_got_b ? r_delay : '0;
          w_no_b_next      = ~r_got_b;
          w_timeout_next   = 1'b0;
        end else if (w_tmo) begin
          w_state_next     = DONE;
          w_period_next    = '0;
          w_delay_out_next = '0;
          w_no_b_next      = 1'b1;
          w_timeout_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_rise_b && !r_got_b) begin
            w_delay_next = r_cnt;
            w_got_b_next = 1'b1;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ina_q     <= 1'b0;
      r_inb_q     <= 1'b0;
      r_hist_vld  <= 1'b0;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_delay     <= '0;
      r_got_b     <= 1'b0;
      r_period    <= '0;
      r_delay_out <= '0;
      r_no_b      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ina_q     <= ina_div;
      r_inb_q     <= inb_div;
      r_hist_vld  <= 1'b1;
      r_timer     <= w_timer_next;
      r_cnt       <= w_cnt_next;
      r_delay     <= w_delay_next;
      r_got_b     <= w_got_b_next;
      r_period    <= w_period_next;
      r_delay_out <= w_delay_out_next;
      r_no_b      <= w_no_b_next;
      r_timeout   <= w_timeout_next;
    end
  end

  assign busy       = (r_state == WAIT_A) || (r_state == MEAS);
  assign done       = (r_state == DONE);
  assign period_cnt = r_period;
  assign delay_cnt  = r_delay_out;
  assign no_b       = r_no_b;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_phase_measure.sv
// Randomized and directed bench for phase_measure; two instances with long and
// short timeouts share the same stimulus and are checked against a trace model.
module tb_phase_measure;

  localparam int T1 = 400;
  localparam int T2 = 20;
  localparam int NMAX = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ina, inb;
  logic busy1, done1, nob1, to1;
  logic [15:0] per1, del1;
  logic busy2, done2, nob2, to2;
  logic [7:0] per2, del2;

  phase_measure #(.CNT_W(16), .TIMEOUT(T1)) dut (
    .clk(clk), .rst(rst), .start(start), .ina_div(ina), .inb_div(inb),
    .busy(busy1), .done(done1), .period_cnt(per1), .delay_cnt(del1),
    .no_b(nob1), .timeout(to1)
  );

  phase_measure #(.CNT_W(8), .TIMEOUT(T2)) dut_to (
    .clk(clk), .rst(rst), .start(start), .ina_div(ina), .inb_div(inb),
    .busy(busy2), .done(done2), .period_cnt(per2), .delay_cnt(del2),
    .no_b(nob2), .timeout(to2)
  );

  int total = 0;
  int bad   = 0;
  bit wa[NMAX];
  bit wb[NMAX];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Square waves: ina starts its first rise at a0; inb is ina delayed by lag, zero before.
  task automatic gen(input int a0, input int p, input int lag, input bit b_en);
    for (int i = 0; i < NMAX; i++) begin
      wa[i] = (i >= a0) && (((i - a0) % p) < p / 2);
      wb[i] = b_en && (i >= a0 + lag) && (((i - a0 - lag) % p) < p / 2);
    end
  endtask

  function automatic bit ra(input int i);
    return (i >= 1) && wa[i] && !wa[i-1];
  endfunction

  function automatic bit rb(input int i);
    return (i >= 1) && wb[i] && !wb[i-1];
  endfunction

  // Reference: start seen at sample s, busy window covers samples s+1 .. s+t.
  task automatic model(input int s, input int t, output int di, output int pc,
                       output int dc, output int nb, output int to);
    int r0, r1;
    r0 = -1;
    r1 = -1;
    for (int i = s + 1; i <= s + t; i++)
      if (r0 < 0 && ra(i)) r0 = i;
    if (r0 >= 0)
      for (int i = r0 + 1; i <= s + t; i++)
        if (r1 < 0 && ra(i)) r1 = i;
    if (r1 < 0) begin
      di = s + t; pc = 0; dc = 0; nb = 1; to = 1;
    end else begin
      di = r1; pc = r1 - r0; dc = 0; nb = 1; to = 0;
      for (int i = r0; i < r1; i++)
        if (nb == 1 && rb(i)) begin
          dc = i - r0;
          nb = 0;
        end
    end
  endtask

  task automatic chk_unit(input string u, input int i, input int s, input int di,
                          input int rst_at, input logic b, input logic d,
                          input logic [31:0] p, input logic [31:0] dl, input logic nb,
                          input logic to, input int epc, input int edc, input int enb,
                          input int eto);
    bit eb, ed;
    if (rst_at < 0) begin
      eb = (i >= s) && (i < di);
      ed = (i == di);
    end else begin
      eb = (i >= s) && (i < rst_at);
      ed = 1'b0;
    end
    chk($sformatf("%s.busy@%0d", u, i), {31'b0, b}, {31'b0, eb});
    chk($sformatf("%s.done@%0d", u, i), {31'b0, d}, {31'b0, ed});
    if ((rst_at < 0 && i == di) || i == rst_at) begin
      chk($sformatf("%s.period@%0d", u, i), p, (rst_at < 0) ? epc : 0);
      chk($sformatf("%s.delay@%0d", u, i), dl, (rst_at < 0) ? edc : 0);
      chk($sformatf("%s.no_b@%0d", u, i), {31'b0, nb}, (rst_at < 0) ? enb : 0);
      chk($sformatf("%s.timeout@%0d", u, i), {31'b0, to}, (rst_at < 0) ? eto : 0);
    end
  endtask

  task automatic run_case(input string name, input int s, input int rst_at);
    int di1, pc1, dc1, nb1, to1e;
    int di2, pc2, dc2, nb2, to2e;
    int n;
    model(s, T1, di1, pc1, dc1, nb1, to1e);
    model(s, T2, di2, pc2, dc2, nb2, to2e);
    n = (rst_at >= 0) ? rst_at + 5 : ((di1 > di2) ? di1 : di2) + 5;
    for (int i = 0; i < n; i++) begin
      rst   = (i == rst_at);
      start = (i == s) || (i == s + 2);
      ina   = wa[i];
      inb   = wb[i];
      @(posedge clk);
      #1;
      chk_unit({name, ".L"}, i, s, di1, rst_at, busy1, done1, {16'b0, per1}, {16'b0, del1},
               nob1, to1, pc1, dc1, nb1, to1e);
      chk_unit({name, ".S"}, i, s, di2, rst_at, busy2, done2, {24'b0, per2}, {24'b0, del2},
               nob2, to2, pc2, dc2, nb2, to2e);
    end
    if (rst_at < 0) begin
      chk({name, ".L.hold_period"}, {16'b0, per1}, pc1);
      chk({name, ".L.hold_delay"}, {16'b0, del1}, dc1);
      chk({name, ".S.hold_period"}, {24'b0, per2}, pc2);
      chk({name, ".S.hold_timeout"}, {31'b0, to2}, to2e);
    end
    rst   = 1'b0;
    start = 1'b0;
    $display("case %s: L period=%0d delay=%0d no_b=%0d to=%0d | S period=%0d delay=%0d no_b=%0d to=%0d",
             name, per1, del1, nob1, to1, per2, del2, nob2, to2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ina = 1'b0; inb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", {31'b0, busy1}, 0);
    chk("reset.done", {31'b0, done1}, 0);
    chk("reset.period", {16'b0, per1}, 0);
    chk("reset.delay", {16'b0, del1}, 0);
    chk("reset.no_b", {31'b0, nob1}, 0);
    chk("reset.timeout", {31'b0, to2}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    gen(10, 100, 25, 1'b1);   run_case("lag25_p100", 3, -1);
    gen(8, 40, 0, 1'b1);      run_case("inphase_p40", 3, -1);
    gen(6, 60, 0, 1'b0);      run_case("nob_p60", 3, -1);
    gen(9, 50, 50, 1'b1);     run_case("lagfull_p50", 3, -1);
    gen(2000, 2, 0, 1'b0);    run_case("static", 3, -1);
    gen(5, 6, 3, 1'b1);       run_case("short_p6", 3, -1);
    gen(5, 18, 4, 1'b1);      run_case("close_at_tmo", 3, -1);
    gen(6, 18, 4, 1'b1);      run_case("close_after_tmo", 3, -1);
    gen(6, 40, 10, 1'b1);     run_case("rst_mid", 3, 11);
    gen(5, 40, 7, 1'b1);      run_case("after_rst", 3, -1);

    for (int k = 0; k < 12; k++) begin
      int p, s, a0, lag;
      bit b_en;
      p    = 2 * $urandom_range(2, 60);
      s    = $urandom_range(3, 10);
      a0   = s + $urandom_range(1, p);
      lag  = $urandom_range(0, p);
      b_en = ($urandom_range(0, 5) != 0);
      gen(a0, p, lag, b_en);
      run_case($sformatf("rand%0d_p%0d_l%0d_b%0d", k, p, lag, b_en), s, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
